// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// state encoding, opcodes, datapath select encodings and the per-state
// Moore output table.
package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR,
      S_LUI, S_AUIPC, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10
   } alu_op_t;

   // Registered Moore outputs. fetch/branch are qualifiers that are
   // combined with mem_ready/zero outside the register.
   typedef struct packed {
      logic        fetch;
      logic        pc_update;
      logic        branch;
      logic        adr_src;
      logic        mem_write;
      logic        reg_write;
      result_src_t result_src;
      alu_src_a_t  alu_src_a;
      alu_src_b_t  alu_src_b;
      alu_op_t     alu_op;
   } ctrl_t;

   function automatic ctrl_t state_outputs(state_t s);
      ctrl_t c;
      c.fetch      = 1'b0;
      c.pc_update  = 1'b0;
      c.branch     = 1'b0;
      c.adr_src    = 1'b0;
      c.mem_write  = 1'b0;
      c.reg_write  = 1'b0;
      c.result_src = RES_ALUOUT;
      c.alu_src_a  = SRCA_PC;
      c.alu_src_b  = SRCB_RS2;
      c.alu_op     = ALU_ADD;
      case (s)
         S_FETCH: begin
            c.fetch      = 1'b1;
            c.result_src = RES_ALURESULT;
            c.alu_src_b  = SRCB_FOUR;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_ADR, S_JALR_ADR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ:  c.adr_src = 1'b1;
         S_MEM_WRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_MEM_WB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_op    = ALU_FUNCT;
         end
         S_EXEC_I: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_FUNCT;
         end
         S_ALU_WB: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_op    = ALU_SUB;
            c.branch    = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_FOUR;
            c.pc_update = 1'b1;
         end
         S_LUI: begin
            c.alu_src_a = SRCA_ZERO;
            c.alu_src_b = SRCB_IMM;
         end
         S_AUIPC: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [2:0] imm_src;
   logic       illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal
   );
endinterface

// File: rtl/multicycle_ctrl_fsm_imm_src_decoder.sv
// Combinational opcode -> immediate format select. Unknown opcodes map
// to the I format so the output is always defined.
module imm_src_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] imm_src
);
   imm_src_t imm_sel;

   // Pick the immediate layout from the major opcode.
   always_comb begin
      imm_sel = IMM_I;
      case (opcode)
         OP_STORE:        imm_sel = IMM_S;
         OP_BRANCH:       imm_sel = IMM_B;
         OP_JAL:          imm_sel = IMM_J;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         default:         imm_sel = IMM_I;
      endcase
   end

   assign imm_src = imm_sel;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main control: Moore FSM sequencing fetch, decode,
// execute, memory and writeback. Select outputs are registered from the
// next state; strobes that depend on mem_ready or zero in the current
// cycle are qualified combinationally and forced low while in reset.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter bit SUPPORT_U     = 1'b1,
   parameter bit SUPPORT_JALR  = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_ctrl_fsm_if.master bus
);
   state_t     state_reg;
   state_t     state_next;
   ctrl_t      ctrl_reg;
   logic       illegal_reg;
   logic       mem_ready_eff;
   logic [2:0] imm_src_w;

   assign mem_ready_eff = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

   imm_src_decoder u_imm_src_decoder (
      .opcode  (bus.opcode),
      .imm_src (imm_src_w)
   );

   // Next-state selection; disabled features and unknown opcodes trap.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:     if (mem_ready_eff) state_next = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
               OP_RTYPE:          state_next = S_EXEC_R;
               OP_ITYPE:          state_next = S_EXEC_I;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR: begin
                  if (SUPPORT_JALR) state_next = S_JALR_ADR;
                  else              state_next = S_TRAP;
               end
               OP_LUI: begin
                  if (SUPPORT_U) state_next = S_LUI;
                  else           state_next = S_TRAP;
               end
               OP_AUIPC: begin
                  if (SUPPORT_U) state_next = S_AUIPC;
                  else           state_next = S_TRAP;
               end
               default:           state_next = S_TRAP;
            endcase
         end
         S_MEM_ADR: begin
            if (bus.opcode[5]) state_next = S_MEM_WRITE;
            else               state_next = S_MEM_READ;
         end
         S_MEM_READ:  if (mem_ready_eff) state_next = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready_eff) state_next = S_FETCH;
         S_MEM_WB:    state_next = S_FETCH;
         S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL: state_next = S_ALU_WB;
         S_JALR_ADR:  state_next = S_JAL;
         S_ALU_WB:    state_next = S_FETCH;
         S_BRANCH:    state_next = S_FETCH;
         S_TRAP:      state_next = S_TRAP;
         default:     state_next = S_FETCH;
      endcase
   end

   // State, registered outputs and the sticky illegal flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_FETCH;
         ctrl_reg    <= state_outputs(S_FETCH);
         illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ctrl_reg  <= state_outputs(state_next);
         if (state_next == S_TRAP) illegal_reg <= 1'b1;
      end
   end

   assign bus.ir_write   = rst_n & ctrl_reg.fetch & mem_ready_eff;
   assign bus.pc_write   = rst_n & ((ctrl_reg.fetch & mem_ready_eff) |
                                    ctrl_reg.pc_update |
                                    (ctrl_reg.branch & bus.zero));
   assign bus.mem_write  = rst_n & ctrl_reg.mem_write;
   assign bus.reg_write  = rst_n & ctrl_reg.reg_write;
   assign bus.adr_src    = ctrl_reg.adr_src;
   assign bus.result_src = ctrl_reg.result_src;
   assign bus.alu_src_a  = ctrl_reg.alu_src_a;
   assign bus.alu_src_b  = ctrl_reg.alu_src_b;
   assign bus.alu_op     = ctrl_reg.alu_op;
   assign bus.imm_src    = imm_src_w;
   assign bus.illegal    = illegal_reg;
endmodule
